// File: rtl/instr_fetch_ctrl_if.sv
// Program-memory read channel between the fetch controller (master) and
// instruction memory (slave).
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_data;
  logic              mem_ack;

  modport master (output mem_addr, mem_rd, input mem_data, mem_ack);
  modport slave  (input mem_addr, mem_rd, output mem_data, mem_ack);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/decode sequencer feeding the ALU control FSM: fetches a
// word, decodes it, strobes ALUstr and waits for aluDone with a timeout.
module instr_fetch_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int RESET_PC    = 0,
  parameter int ALU_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  instr_fetch_ctrl_if.master mem,
  output logic              ALUstr,
  output logic [3:0]        opCode,
  output logic [3:0]        regI,
  output logic [3:0]        regJ,
  output logic [7:0]        imm,
  input  logic              aluDone,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int CNT_W = (ALU_TIMEOUT > 2) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM, S_DECODE, S_DISPATCH, S_WAIT, S_HALTED
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        ir, ir_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               fault_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= ADDR_W'(RESET_PC);
      ir    <= 16'h0000;
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      cnt   <= cnt_nxt;
      fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    cnt_nxt   = cnt;
    fault_nxt = fault;
    case (state)
      S_IDLE:
        if (run) state_nxt = S_MEM;
      S_MEM:
        if (mem.mem_ack) begin
          ir_nxt    = mem.mem_data;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
      S_DECODE:
        if (ir[15:12] <= 4'd8) begin
          state_nxt = S_DISPATCH;
        end else if (ir[15:12] == 4'd9) begin
          pc_nxt    = ADDR_W'(ir[7:0]);
          state_nxt = S_IDLE;
        end else if (ir[15:12] == 4'd15) begin
          state_nxt = S_HALTED;
        end else begin
          state_nxt = S_IDLE;
        end
      S_DISPATCH: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT:
        // Only a clean logic 1 counts as done; done beats the timeout.
        if (aluDone == 1'b1) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          fault_nxt = 1'b1;
          state_nxt = S_HALTED;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign mem.mem_addr = pc;
  assign mem.mem_rd   = (state == S_MEM);
  assign ALUstr       = (state == S_DISPATCH);
  assign busy         = (state == S_MEM) || (state == S_DECODE) ||
                        (state == S_DISPATCH) || (state == S_WAIT);
  assign halted       = (state == S_HALTED);
  assign opCode       = ir[15:12];
  assign regI         = ir[11:8];
  assign regJ         = ir[7:4];
  assign imm          = ir[7:0];

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand-written timeout /
// halt / reset sequences, and random instructions against an ISA-level model.
module tb_instr_fetch_ctrl;
  localparam int T = 32;

  logic       clk, reset, run, ALUstr, aluDone, busy, halted, fault;
  logic [3:0] opCode, regI, regJ;
  logic [7:0] imm, pc;
  int         checks, failures;

  instr_fetch_ctrl_if #(.ADDR_W(8)) bus();

  instr_fetch_ctrl #(.ADDR_W(8), .RESET_PC(0), .ALU_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .run(run), .mem(bus),
    .ALUstr(ALUstr), .opCode(opCode), .regI(regI), .regJ(regJ), .imm(imm),
    .aluDone(aluDone), .pc(pc), .busy(busy), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int          ack_dly;
    int          alu_dly;
    logic [7:0]  addr;
    logic [3:0]  op;
    logic [3:0]  ri;
    logic [3:0]  rj;
    logic [7:0]  im;
    logic        str;
    logic [7:0]  pc_after;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_rd"}, bus.mem_rd, 0);
    chk({tag, " ALUstr"}, ALUstr, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " halted"}, halted, 0);
    chk({tag, " fault"}, fault, 0);
    chk({tag, " pc"}, pc, 0);
    chk({tag, " ir_fields"}, {opCode, regI, regJ, imm}, 0);
  endtask

  // Starts in IDLE at a negedge; ends at the negedge inside DECODE.
  task automatic fetch_decode(input logic [15:0] w, input int ack_dly, input logic [7:0] addr,
                              input logic [3:0] eop, input logic [3:0] ei,
                              input logic [3:0] ej, input logic [7:0] eim);
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= ack_dly; k++) begin
      chk("mem_rd in MEM", bus.mem_rd, 1);
      chk("mem_addr in MEM", bus.mem_addr, addr);
      chk("busy in MEM", busy, 1);
      chk("ALUstr in MEM", ALUstr, 0);
      bus.mem_ack  = (k == ack_dly);
      bus.mem_data = (k == ack_dly) ? w : 16'($urandom);
      aluDone      = 1'($urandom);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    chk("opCode", opCode, eop);
    chk("regI", regI, ei);
    chk("regJ", regJ, ej);
    chk("imm", imm, eim);
    chk("ALUstr in DECODE", ALUstr, 0);
    chk("mem_rd in DECODE", bus.mem_rd, 0);
    chk("busy in DECODE", busy, 1);
  endtask

  // Continues from DECODE; ends at the negedge back in IDLE.
  task automatic finish_instr(input logic str, input int alu_dly, input logic [7:0] epc,
                              input logic [3:0] eop, input logic [7:0] eim);
    bus.mem_ack  = 1'($urandom);
    bus.mem_data = 16'($urandom);
    aluDone      = 1'($urandom);
    if (str) begin
      @(negedge clk);
      chk("ALUstr in DISPATCH", ALUstr, 1);
      chk("busy in DISPATCH", busy, 1);
      bus.mem_ack = 1'($urandom);
      aluDone     = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k < alu_dly; k++) begin
        chk("ALUstr in WAIT", ALUstr, 0);
        chk("busy in WAIT", busy, 1);
        chk("fields stable in WAIT", {opCode, imm}, {eop, eim});
        chk("fault in WAIT", fault, 0);
        if (k == 0) run = 1'b0;
        aluDone      = (k == alu_dly - 1);
        bus.mem_ack  = 1'($urandom);
        bus.mem_data = 16'($urandom);
        @(negedge clk);
      end
      aluDone = 1'b0;
    end else begin
      run = 1'b0;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    chk("busy after instr", busy, 0);
    chk("mem_rd after instr", bus.mem_rd, 0);
    chk("ALUstr after instr", ALUstr, 0);
    chk("halted after instr", halted, 0);
    chk("pc after instr", pc, epc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  model_pc;
    logic [15:0] w;
    logic [3:0]  op;
    logic        str;
    logic [7:0]  npc;
    int          ad, ld;

    checks = 0; failures = 0;
    reset = 1'b1; run = 1'b0; aluDone = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_data = 16'h0;

    tbl[0] = '{16'h0123, 0,  2, 8'h00, 4'h0, 4'h1, 4'h2, 8'h23, 1'b1, 8'h01};
    tbl[1] = '{16'h7A05, 5,  1, 8'h01, 4'h7, 4'hA, 4'h0, 8'h05, 1'b1, 8'h02};
    tbl[2] = '{16'hA000, 1,  1, 8'h02, 4'hA, 4'h0, 4'h0, 8'h00, 1'b0, 8'h03};
    tbl[3] = '{16'h9042, 0,  1, 8'h03, 4'h9, 4'h0, 4'h4, 8'h42, 1'b0, 8'h42};
    tbl[4] = '{16'h8155, 2,  3, 8'h42, 4'h8, 4'h1, 4'h5, 8'h55, 1'b1, 8'h43};
    tbl[5] = '{16'h90FF, 0,  1, 8'h43, 4'h9, 4'h0, 4'hF, 8'hFF, 1'b0, 8'hFF};
    tbl[6] = '{16'hA000, 0,  1, 8'hFF, 4'hA, 4'h0, 4'h0, 8'h00, 1'b0, 8'h00};
    tbl[7] = '{16'hE3C7, 1,  1, 8'h00, 4'hE, 4'h3, 4'hC, 8'hC7, 1'b0, 8'h01};
    tbl[8] = '{16'h2345, 0,  4, 8'h01, 4'h2, 4'h3, 4'h4, 8'h45, 1'b1, 8'h02};
    tbl[9] = '{16'h1234, 3,  T, 8'h02, 4'h1, 4'h2, 4'h3, 8'h34, 1'b1, 8'h03};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle without run", busy, 0);

    foreach (tbl[i]) begin
      fetch_decode(tbl[i].w, tbl[i].ack_dly, tbl[i].addr, tbl[i].op, tbl[i].ri, tbl[i].rj, tbl[i].im);
      finish_instr(tbl[i].str, tbl[i].alu_dly, tbl[i].pc_after, tbl[i].op, tbl[i].im);
    end

    // Parked in IDLE with run low; stray acks must be ignored.
    for (int k = 0; k < 3; k++) begin
      bus.mem_ack = 1'b1; bus.mem_data = 16'hFFFF;
      @(negedge clk);
      chk("parked mem_rd", bus.mem_rd, 0);
      chk("parked busy", busy, 0);
      chk("parked opCode", opCode, 4'h1);
    end
    bus.mem_ack = 1'b0;

    model_pc = 8'h03;
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'($urandom_range(0, 14));
      op  = w[15:12];
      str = (op <= 4'd8);
      npc = (op == 4'd9) ? w[7:0] : model_pc + 8'd1;
      ad  = $urandom_range(0, 3);
      ld  = ($urandom_range(0, 7) == 0) ? T : $urandom_range(1, 4);
      fetch_decode(w, ad, model_pc, op, w[11:8], w[7:4], w[7:0]);
      finish_instr(str, ld, npc, op, w[7:0]);
      model_pc = npc;
    end

    // HALT, then an asynchronous reset between clock edges.
    fetch_decode(16'hF000, 1, model_pc, 4'hF, 4'h0, 4'h0, 8'h00);
    run = 1'b0;
    @(negedge clk);
    chk("halt halted", halted, 1);
    chk("halt busy", busy, 0);
    chk("halt ALUstr", ALUstr, 0);
    chk("halt fault", fault, 0);
    chk("halt pc", pc, model_pc + 8'd1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("async reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ALU never completes: fault after T cycles in WAIT_ALU.
    fetch_decode(16'h1234, 0, 8'h00, 4'h1, 4'h2, 4'h3, 8'h34);
    aluDone = 1'b0;
    @(negedge clk);
    chk("timeout ALUstr", ALUstr, 1);
    run = 1'b0;
    repeat (T) @(negedge clk);
    chk("timeout last wait busy", busy, 1);
    chk("timeout last wait fault", fault, 0);
    @(negedge clk);
    chk("timeout fault", fault, 1);
    chk("timeout halted", halted, 1);
    chk("timeout busy", busy, 0);
    run = 1'b1; bus.mem_ack = 1'b1; aluDone = 1'b1;
    repeat (5) @(negedge clk);
    chk("stuck halted", halted, 1);
    chk("stuck fault", fault, 1);
    chk("stuck mem_rd", bus.mem_rd, 0);
    chk("stuck pc", pc, 8'h01);
    run = 1'b0; bus.mem_ack = 1'b0; aluDone = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("final reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Upstream sequencer for the ALU-operation control FSM.
- Fetches 16-bit instruction words from program memory and decodes the opcode and register/immediate fields.
- Issues a one-cycle start strobe (ALUstr) to the ALU FSM, then waits for its completion flag before fetching again.
- Handles JMP and HALT locally, and halts with a fault if the ALU FSM never completes.

Parameters:
ADDR_W, 8, program-counter / memory-address width (8..16)
RESET_PC, 0, PC value loaded on reset
ALU_TIMEOUT, 32, max cycles spent in WAIT_ALU before fault (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  fetch enable, sampled in IDLE
mem_addr  output  ADDR_W  program memory address (= PC)
mem_rd  output  1  memory read request
mem_data  input  16  instruction word, valid when mem_ack=1
mem_ack  input  1  memory read acknowledge
ALUstr  output  1  start strobe to ALU FSM
opCode  output  4  IR[15:12]
regI  output  4  IR[11:8], destination/source-1 register index
regJ  output  4  IR[7:4], source-2 register index
imm  output  8  IR[7:0], immediate
aluDone  input  1  ALU FSM completion flag (may float z when the ALU FSM is idle)
pc  output  ADDR_W  current PC
busy  output  1  instruction in progress
halted  output  1  HALTED state
fault  output  1  ALU timeout occurred

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - State=IDLE, PC=RESET_PC, IR=16'h0000, timeout counter=0.
  - Outputs: mem_rd=0, ALUstr=0, busy=0, halted=0, fault=0.
  - opCode/regI/regJ/imm=0.
- Reset asserted mid-operation aborts immediately; no pending request persists.
- All outputs are registered or decoded from registered state (Moore); there are no combinational paths from inputs to outputs.
- Opcodes:
  - 0..8: ALU ops (ADD, SUB, NOT, AND, OR, XOR, XNOR, ADDI, SUBI).
  - 9: JMP.
  - 15: HALT.
  - 10..14: NOP.
- State machine:
  - IDLE: busy=0. If run=1 at the clock edge, go to MEM; else stay.
  - MEM: mem_rd=1, mem_addr=PC.
    - On an edge with mem_ack=1: IR<=mem_data, PC<=PC+1 (wraps modulo 2^ADDR_W), go to DECODE.
    - Otherwise stay; there is no timeout on memory.
  - DECODE (1 cycle): the IR fields are already visible on outputs.
    - Opcode 0..8 -> DISPATCH.
    - JMP -> PC<=imm zero-extended (or truncated) to ADDR_W, go to IDLE.
    - HALT -> HALTED.
    - NOP -> IDLE.
  - DISPATCH (1 cycle): ALUstr=1 for exactly this cycle; clear the counter; go to WAIT_ALU.
  - WAIT_ALU: ALUstr=0.
    - If aluDone is exactly logic 1 at the edge, go to IDLE. Values 0, z and x are all not-done.
    - Otherwise counter+1.
    - If the counter reaches ALU_TIMEOUT-1 without done: fault<=1, go to HALTED.
  - HALTED: halted=1, busy=0, fault holds its value. Exited only by reset.
- busy=1 in MEM, DECODE, DISPATCH, WAIT_ALU.
- opCode, regI, regJ and imm are stable from DECODE through WAIT_ALU. IR changes only on a MEM acknowledge.
- Latency, with mem_ack in the first MEM cycle:
  - Edge where IDLE samples run=1 = cycle 0.
  - ALUstr is high during cycle 3.
  - Minimum per-instruction period is IDLE + MEM + DECODE + DISPATCH + WAIT_ALU + ALU duration.
- Boundary rules:
  - mem_ack outside MEM is ignored.
  - aluDone outside WAIT_ALU is ignored.
  - run deasserted mid-instruction: the instruction completes and the block parks in IDLE.
  - aluDone=1 on the same edge the counter reaches its limit: done wins, go to IDLE with no fault.
  - PC=2^ADDR_W-1 fetch: PC wraps to 0.
  - JMP to the current address is legal and loops forever.

Test Plan:
- Reset, run=1, mem returns 16'h0123 with ack in the first MEM cycle.
  -> opCode=0, regI=1, regJ=2; ALUstr high for exactly 1 cycle, 3 cycles after run sampled.
  -> aluDone=1 two cycles later returns to IDLE; pc=1.
- Memory ack delayed 5 cycles on word 16'h7A05.
  -> mem_rd stays high and mem_addr stays constant for 6 cycles; then opCode=7, regI=10, imm=8'h05, ALUstr pulse.
- Word 16'h9042 at PC=3 -> no ALUstr; pc=8'h42 next; the next fetch is at mem_addr=8'h42.
- aluDone held z/0 after dispatch -> after ALU_TIMEOUT cycles fault=1, halted=1, busy=0; further run/ack has no effect until reset.
- Word 16'hF000 -> halted=1, no ALUstr.
  -> Assert reset asynchronously mid-cycle: halted=0, pc=RESET_PC, and all outputs return to reset values before the next edge.
- PC preset to 8'hFF via JMP 16'h90FF, then fetch NOP 16'hA000 -> pc wraps to 0.
  -> Drop run during WAIT_ALU: the instruction completes and the block stays in IDLE with mem_rd=0.
